// File: rtl/ring_counter_param_if.sv
`default_nettype none
// ============================================================================
// Module   : ring_counter_param_if
// Brief    : Control/status bundle between switch logic and the step counter.
// Revision : 1.0
// ============================================================================
interface ring_counter_param_if #(
   parameter int NBITS = 4
) ();
   localparam int IDXW = $clog2(2 * NBITS);

   logic             en;
   logic             dir;
   logic             mode;
   logic             load;
   logic [IDXW-1:0]  load_pos;
   logic [NBITS-1:0] q;
   logic [IDXW-1:0]  pos;
   logic             tick;
   logic             wrap;
   logic [7:0]       seg;

   modport master (
      output en, dir, mode, load, load_pos,
      input  q, pos, tick, wrap, seg
   );

   modport slave (
      input  en, dir, mode, load, load_pos,
      output q, pos, tick, wrap, seg
   );
endinterface
`default_nettype wire

// File: rtl/ring_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : ring_counter_param
// Brief    : Ring / Johnson step counter with prescaler, load and position out.
//            Optional macro SEG7_EN adds a hex 7-segment decode of pos.
// Revision : 1.0
// ============================================================================
module ring_counter_param #(
   parameter int NBITS = 4,
   parameter int DIV   = 1
) (
   input  logic                  clk_2,
   input  logic                  reset,
   ring_counter_param_if.slave   bus
);
   localparam int IDXW = $clog2(2 * NBITS);
   localparam int PREW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PREW-1:0] PRE_LAST  = PREW'(DIV - 1);
   localparam logic [IDXW-1:0] RING_LAST = IDXW'(NBITS - 1);
   localparam logic [IDXW-1:0] JOHN_LAST = IDXW'(2 * NBITS - 1);

   logic [NBITS-1:0] q_q,    q_d;
   logic [IDXW-1:0]  pos_q,  pos_d;
   logic [PREW-1:0]  pre_q,  pre_d;
   logic             mode_q, mode_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;

   logic [IDXW-1:0]  pos_last;
   logic             load_ok;

   // Canonical state vector for a position: one-hot in ring mode, a run of
   // ones growing from the LSB then shrinking toward the MSB in Johnson mode.
   function automatic logic [NBITS-1:0] canon(input logic jmode,
                                              input logic [IDXW-1:0] p);
      logic [NBITS-1:0] r;
      int               pi;
      pi = int'(p);
      r  = '0;
      for (int i = 0; i < NBITS; i++) begin
         if (!jmode)
            r[i] = (i == pi);
         else if (pi <= NBITS)
            r[i] = (i < pi);
         else
            r[i] = (i >= pi - NBITS);
      end
      return r;
   endfunction

   always_comb begin
      pos_last = mode_q ? JOHN_LAST : RING_LAST;
      load_ok  = bus.load && (bus.load_pos <= pos_last);
   end

   always_comb begin
      q_d    = q_q;
      pos_d  = pos_q;
      pre_d  = pre_q;
      mode_d = mode_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;

      if (bus.mode != mode_q) begin
         mode_d = bus.mode;
         pre_d  = '0;
         pos_d  = '0;
         q_d    = bus.mode ? '0 : NBITS'(1);
      end else if (load_ok) begin
         pos_d = bus.load_pos;
         q_d   = canon(mode_q, bus.load_pos);
         pre_d = '0;
      end else if (bus.en) begin
         if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            // The bit wrapping around is inverted only in Johnson mode.
            if (!bus.dir) begin
               q_d = {q_q[NBITS-2:0], q_q[NBITS-1] ^ mode_q};
               if (pos_q == pos_last) begin
                  pos_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q + IDXW'(1);
               end
            end else begin
               q_d = {q_q[0] ^ mode_q, q_q[NBITS-1:1]};
               if (pos_q == '0) begin
                  pos_d  = pos_last;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q - IDXW'(1);
               end
            end
         end else begin
            pre_d = pre_q + PREW'(1);
         end
      end
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         q_q    <= NBITS'(1);
         pos_q  <= '0;
         pre_q  <= '0;
         mode_q <= 1'b0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         pos_q  <= pos_d;
         pre_q  <= pre_d;
         mode_q <= mode_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.q    = q_q;
   assign bus.pos  = pos_q;
   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;

`ifdef SEG7_EN
   logic [3:0] hex_nib;
   logic [6:0] seg7;

   always_comb begin
      hex_nib = 4'(pos_q);
      seg7    = 7'h00;
      case (hex_nib)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   end

   assign bus.seg = {bus.dir, seg7};
`else
   assign bus.seg = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_counter_param
// Brief    : Scoreboard bench for ring_counter_param (DIV=1 and DIV=3 copies).
// Revision : 1.0
// ============================================================================
module tb_ring_counter_param;

   logic       clk_2;
   logic       reset;
   logic       t_en, t_dir, t_mode, t_load;
   logic [2:0] t_load_pos;

   int n_checks = 0;
   int n_fail   = 0;

   ring_counter_param_if #(.NBITS(4)) bus1 ();
   ring_counter_param_if #(.NBITS(4)) bus3 ();

   assign bus1.en = t_en;   assign bus1.dir = t_dir;  assign bus1.mode = t_mode;
   assign bus1.load = t_load; assign bus1.load_pos = t_load_pos;
   assign bus3.en = t_en;   assign bus3.dir = t_dir;  assign bus3.mode = t_mode;
   assign bus3.load = t_load; assign bus3.load_pos = t_load_pos;

   ring_counter_param #(.NBITS(4), .DIV(1)) dut1 (.clk_2(clk_2), .reset(reset), .bus(bus1));
   ring_counter_param #(.NBITS(4), .DIV(3)) dut3 (.clk_2(clk_2), .reset(reset), .bus(bus3));

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   typedef struct {
      int pos;
      bit modeq;
      int pre;
      bit tick;
      bit wrap;
   } mst_t;

   typedef struct {
      mst_t       a;
      mst_t       b;
      logic [7:0] seg_a;
      logic [7:0] seg_b;
   } exp_t;

   exp_t sb[$];
   mst_t m1, m3;
   logic [6:0] hex7 [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic mst_t mreset();
      mst_t s;
      s.pos = 0; s.modeq = 0; s.pre = 0; s.tick = 0; s.wrap = 0;
      return s;
   endfunction

   function automatic logic [3:0] pat(bit j, int p);
      logic [3:0] ones;
      ones = 4'hF;
      if (!j)     return 4'(1 << p);
      if (p <= 4) return 4'((1 << p) - 1);
      return ones << (p - 4);
   endfunction

   function automatic logic [7:0] seg_exp(int p, logic d);
`ifdef SEG7_EN
      return {d, hex7[p]};
`else
      return 8'h00;
`endif
   endfunction

   function automatic mst_t mnext(mst_t s, int div);
      mst_t n;
      int   m;
      n = s; n.tick = 0; n.wrap = 0;
      m = s.modeq ? 8 : 4;
      if (t_mode != s.modeq) begin
         n.modeq = t_mode; n.pre = 0; n.pos = 0;
      end else if (t_load && int'(t_load_pos) < m) begin
         n.pos = int'(t_load_pos); n.pre = 0;
      end else if (t_en) begin
         if (s.pre == div - 1) begin
            n.pre = 0; n.tick = 1;
            if (!t_dir) begin
               n.wrap = (s.pos == m - 1);
               n.pos  = (s.pos + 1) % m;
            end else begin
               n.wrap = (s.pos == 0);
               n.pos  = (s.pos + m - 1) % m;
            end
         end else begin
            n.pre = s.pre + 1;
         end
      end
      return n;
   endfunction

   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check("q1",    32'(bus1.q),    32'(pat(e.a.modeq, e.a.pos)));
      check("pos1",  32'(bus1.pos),  32'(e.a.pos));
      check("tick1", 32'(bus1.tick), 32'(e.a.tick));
      check("wrap1", 32'(bus1.wrap), 32'(e.a.wrap));
      check("seg1",  32'(bus1.seg),  32'(e.seg_a));
      check("q3",    32'(bus3.q),    32'(pat(e.b.modeq, e.b.pos)));
      check("pos3",  32'(bus3.pos),  32'(e.b.pos));
      check("tick3", 32'(bus3.tick), 32'(e.b.tick));
      check("wrap3", 32'(bus3.wrap), 32'(e.b.wrap));
      check("seg3",  32'(bus3.seg),  32'(e.seg_b));
   endtask

   // Inputs are set while clk_2 is low; expectation is queued, then checked after the edge.
   task automatic run_cycle();
      exp_t e;
      m1 = mnext(m1, 1);
      m3 = mnext(m3, 3);
      e.a = m1; e.b = m3;
      e.seg_a = seg_exp(m1.pos, t_dir);
      e.seg_b = seg_exp(m3.pos, t_dir);
      sb.push_back(e);
      @(posedge clk_2); #1;
      compare_head();
      @(negedge clk_2);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_q1"},   32'(bus1.q),    32'h1);
      check({tag, "_pos1"}, 32'(bus1.pos),  32'h0);
      check({tag, "_tick1"},32'(bus1.tick), 32'h0);
      check({tag, "_wrap1"},32'(bus1.wrap), 32'h0);
      check({tag, "_q3"},   32'(bus3.q),    32'h1);
      check({tag, "_pos3"}, 32'(bus3.pos),  32'h0);
   endtask

   logic [3:0] t1_q   [0:3] = '{4'h2, 4'h4, 4'h8, 4'h1};
   logic       t1_w   [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [3:0] t2_q   [0:7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
   logic       t3_en  [0:4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   logic       t3_tk  [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] seg_dp_exp;

   initial begin
      reset = 1'b1;
      t_en = 0; t_dir = 0; t_mode = 0; t_load = 0; t_load_pos = '0;
      m1 = mreset(); m3 = mreset();
      repeat (2) @(posedge clk_2);
      @(negedge clk_2);
      check_reset_state("rst");
      reset = 1'b0;

      // Ring count up with wrap on 1000 -> 0001
      t_en = 1;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         check("t1_q",    32'(bus1.q),    32'(t1_q[i]));
         check("t1_wrap", 32'(bus1.wrap), 32'(t1_w[i]));
      end

      // Johnson resync then full up sequence
      t_mode = 1;
      run_cycle();
      check("t2_resync", 32'(bus1.q), 32'h0);
      for (int i = 0; i < 8; i++) begin
         run_cycle();
         check("t2_q",   32'(bus1.q),   32'(t2_q[i]));
         check("t2_pos", 32'(bus1.pos), 32'((i + 1) % 8));
      end
      check("t2_wrap", 32'(bus1.wrap), 32'h1);

      // Prescaler DIV=3 with a hold cycle
      t_mode = 0; t_en = 0;
      run_cycle();
      for (int i = 0; i < 5; i++) begin
         t_en = t3_en[i];
         run_cycle();
         check("t3_tick", 32'(bus3.tick), 32'(t3_tk[i]));
      end
      check("t3_q", 32'(bus3.q), 32'h2);

      // Load beats step; out-of-range load ignored
      t_en = 1; t_load = 1; t_load_pos = 3'd2;
      run_cycle();
      check("t4_q",    32'(bus1.q),    32'h4);
      check("t4_pos",  32'(bus1.pos),  32'h2);
      check("t4_tick", 32'(bus1.tick), 32'h0);
      t_load_pos = 3'd5;
      run_cycle();
      check("t4_ign_q",    32'(bus1.q),    32'h8);
      check("t4_ign_tick", 32'(bus1.tick), 32'h1);
      t_load = 0;

      // Johnson down step from position 0 wraps to 7
      t_mode = 1; t_en = 0;
      run_cycle();
      t_dir = 1; t_en = 1;
      run_cycle();
      check("t5_q",    32'(bus1.q),    32'h8);
      check("t5_pos",  32'(bus1.pos),  32'h7);
      check("t5_wrap", 32'(bus1.wrap), 32'h1);

      for (int i = 0; i < 300; i++) begin
         t_en       = ($urandom_range(0, 3) != 0);
         t_dir      = 1'($urandom_range(0, 1));
         t_load     = ($urandom_range(0, 9) == 0);
         t_load_pos = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) t_mode = ~t_mode;
         run_cycle();
      end

      // Asynchronous reset between clock edges
      t_load = 0; t_en = 1; t_mode = 0; t_dir = 0;
      #2 reset = 1'b1;
      #1 check_reset_state("arst");
      m1 = mreset(); m3 = mreset();
      @(posedge clk_2); #1;
      check_reset_state("arst_hold");
      @(negedge clk_2);
      reset = 1'b0;

      // 7-segment decode with dp following dir
      run_cycle();
      t_en = 0; t_dir = 1;
      #1;
`ifdef SEG7_EN
      seg_dp_exp = 8'h86;
`else
      seg_dp_exp = 8'h00;
`endif
      check("t6_seg", 32'(bus1.seg), 32'(seg_dp_exp));
      run_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
